// File: rtl/data_mem_responder.sv
// Word-wide data memory answering the core's data port after WAIT_CYCLES wait states; 2+WAIT_CYCLES cycle latency.
// Define DATA_MEM_RANGE_CHECK_EN to flag and suppress accesses with nonzero address bits above the array.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic                  oor_q;
  logic                  oor_now;
  logic                  commit;
  logic                  unused_addr;
  logic [31:0]           mem [DEPTH];

`ifdef DATA_MEM_RANGE_CHECK_EN
  assign oor_now = |data_addr[31:DEPTH_LOG2+2];
`else
  assign oor_now = 1'b0;
`endif

  // Byte-lane bits never matter; upper bits only matter when range checking is built in.
  assign unused_addr = ^{data_addr[31:DEPTH_LOG2+2], data_addr[1:0]};

  // Reset on the commit edge must suppress the write, so it gates the commit directly.
  assign commit = (state == BUSY) && (cnt == 4'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      data_in   <= 32'h0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            state <= BUSY;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_err   <= oor_q;
            if (!we_q) data_in <= oor_q ? 32'h0 : mem[idx_q];
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields are captured only at acceptance; later bus activity is ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_req) begin
      idx_q   <= data_addr[DEPTH_LOG2+1:2];
      we_q    <= mem_we;
      wdata_q <= data_out;
      oor_q   <= oor_now;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q && !oor_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked by directed tables and a random model.
`timescale 1ns/1ps
module tb_data_mem_responder;
  localparam int NI = 3;
  localparam int DL = 10;
`ifdef DATA_MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdat  [NI];
  logic [31:0] din   [NI];
  logic        rdy   [NI];
  logic        err_o [NI];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [31:0] mdl [NI][1024];
  logic [31:0] last_rd [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_LOG2 (DL),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .mem_req  (req[g]),
      .mem_we   (we[g]),
      .data_addr(addr[g]),
      .data_out (wdat[g]),
      .data_in  (din[g]),
      .mem_ready(rdy[g]),
      .mem_err  (err_o[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % (1 << DL));
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return RC && (a >= 32'h0000_1000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one request in an IDLE cycle, scrambles the bus afterwards, waits for the ready pulse.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, output int lat, output logic [31:0] rd, output logic e,
                        output int t0);
    @(posedge clk); #1;
    chk("idle_rdy", {31'h0, rdy[d]}, 32'h0);
    chk("idle_err", {31'h0, err_o[d]}, 32'h0);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = wd;
    t0 = cyc; lat = -1; rd = 'x; e = 1'bx;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      req[d]  = hold ? 1'b1 : 1'($urandom);
      we[d]   = 1'($urandom);
      addr[d] = $urandom;
      wdat[d] = $urandom;
      if (rdy[d]) begin
        lat = k; rd = din[d]; e = err_o[d];
        break;
      end
      chk("busy_err", {31'h0, err_o[d]}, 32'h0);
      chk("busy_din", din[d], last_rd[d]);
    end
    req[d] = hold;
  endtask

  task automatic txn(input string name, input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold, input logic [31:0] exp_rd,
                     input bit exp_err, output int t0);
    int lat; logic [31:0] rd; logic e;
    access(d, w, a, wd, hold, lat, rd, e, t0);
    chk({name, "_lat"}, lat, 32'(2 + wait_of(d)));
    chk({name, "_din"}, rd, exp_rd);
    chk({name, "_err"}, {31'h0, e}, {31'h0, exp_err});
    if (w && !oor(a)) mdl[d][widx(a)] = wd;
    if (!w) last_rd[d] = exp_rd;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input bit exp_err);
    vec_t v;
    v.w = w; v.a = a; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vt [12];
    int          t0, t1;
    logic [31:0] word0_rd;

    word0_rd = RC ? 32'h0 : 32'hA5A5_0000;
    vt[0]  = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0);
    vt[1]  = mk(0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    vt[2]  = mk(1, 32'h0000_0014, 32'h0000_0055, 32'hDEAD_BEEF, 0);
    vt[3]  = mk(1, 32'h0000_0010, 32'h0BAD_F00D, 32'hDEAD_BEEF, 0);
    vt[4]  = mk(1, 32'h0000_0040, 32'h0000_0011, 32'hDEAD_BEEF, 0);
    vt[5]  = mk(0, 32'h0000_0043, 32'h0,         32'h0000_0011, 0);
    vt[6]  = mk(1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0011, 0);
    vt[7]  = mk(0, 32'h0000_1000, 32'h0,         word0_rd,      RC);
    vt[8]  = mk(1, 32'h0000_0004, 32'h0000_1111, word0_rd,      0);
    vt[9]  = mk(1, 32'h0000_1004, 32'h0000_0BAD, word0_rd,      RC);
    vt[10] = mk(0, 32'h0000_0004, 32'h0,         RC ? 32'h0000_1111 : 32'h0000_0BAD, 0);
    vt[11] = mk(0, 32'h0000_0010, 32'h0,         32'h0BAD_F00D, 0);

    for (int d = 0; d < NI; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) begin
      rst[d] = 1'b0;
      last_rd[d] = 32'h0;
      chk("reset_din", din[d], 32'h0);
      chk("reset_rdy", {31'h0, rdy[d]}, 32'h0);
      chk("reset_err", {31'h0, err_o[d]}, 32'h0);
    end

    for (int i = 0; i < 12; i++)
      txn($sformatf("vec%0d", i), 0, vt[i].w, vt[i].a, vt[i].wd, 1'b0, vt[i].exp_rd, vt[i].exp_err, t0);

    // Zero wait states, request held high: pulses two and five cycles after the first request.
    txn("zw_wr", 1, 1, 32'h0000_0FFC, 32'h600D_CAFE, 1'b1, 32'h0, 0, t0);
    txn("zw_rd", 1, 0, 32'h0000_0FFC, 32'h0, 1'b1, 32'h600D_CAFE, 0, t1);
    req[1] = 1'b0;
    chk("zw_gap", 32'(t1 - t0), 32'd3);

    txn("pre_w",  2, 1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 0, t0);
    txn("pre_w2", 2, 1, 32'h24, 32'h0000_0077, 1'b0, 32'h0, 0, t0);
    txn("pre_r",  2, 0, 32'h24, 32'h0, 1'b0, 32'h0000_0077, 0, t0);

    // Reset during the second BUSY cycle discards the pending write.
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdat[2] = 32'h1234_5678;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      req[2] = 1'b0;
      chk("abort_rdy", {31'h0, rdy[2]}, 32'h0);
    end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("abort_rst_rdy", {31'h0, rdy[2]}, 32'h0);
    chk("abort_rst_din", din[2], 32'h0);
    last_rd[2] = 32'h0;
    txn("abort_rd", 2, 0, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 0, t0);

    // Reset coinciding with the commit edge also wins.
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdat[2] = 32'h8765_4321;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      req[2] = 1'b0;
      chk("commit_rdy", {31'h0, rdy[2]}, 32'h0);
    end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("commit_rst_rdy", {31'h0, rdy[2]}, 32'h0);
    chk("commit_rst_din", din[2], 32'h0);
    last_rd[2] = 32'h0;
    txn("commit_rd", 2, 0, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 0, t0);

    // Random traffic over a 16-word window, with occasional upper-bit aliasing and byte offsets.
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 16; i++)
        txn("rnd_init", d, 1, 32'h100 + 32'(i * 4), $urandom, 1'b0, last_rd[d], 0, t0);
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a, wd, exp;
        bit          w, hold;
        a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
        w = 1'($urandom);
        wd = $urandom;
        hold = 1'($urandom);
        exp = w ? last_rd[d] : (oor(a) ? 32'h0 : mdl[d][widx(a)]);
        txn("rnd", d, w, a, wd, hold, exp, oor(a), t0);
      end
      req[d] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
